// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core LSU and a debug/loader
// master. The core has priority by default. A starvation counter makes sure a
// waiting debug request eventually wins. A debug lock gives a debug burst
// exclusive use of the port until the lock is released.
//
// Ports
//   i_clk, i_reset      clock (rising edge), synchronous active-high reset
//   i_core_*            core request: req, wren (1=store), addr, wdata
//   o_core_gnt          core access issued to memory this cycle
//   o_core_rvalid/rdata core load data, one cycle after a load grant
//   o_core_stall        core_req & !core_gnt
//   i_dbg_*             debug request: req, wren, lock, addr, wdata
//   o_dbg_gnt           debug access issued to memory this cycle
//   o_dbg_rvalid/rdata  debug load data, one cycle after a load grant
//   o_mem_*             memory command: req, wren, addr, wdata
//   i_mem_rdata         memory read data, valid one cycle after a load command
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // core LSU
  input  logic              i_core_req,
  input  logic              i_core_wren,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_gnt,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_stall,
  // debug / loader master
  input  logic              i_dbg_req,
  input  logic              i_dbg_wren,
  input  logic              i_dbg_lock,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  // data memory
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic {
    ST_ARB,
    ST_DBG_BURST
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } owner_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_e            owner_q, owner_d;

  logic core_gnt;
  logic dbg_gnt;

  // ---------------------------------------------------------------------------
  // Arbitration and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    state_d  = state_q;

    case (state_q)
      ST_ARB: begin
        // Debug takes the port when the core is quiet, or once it has been
        // denied MAX_WAIT cycles in a row.
        dbg_gnt  = i_dbg_req & (~i_core_req | (wait_cnt_q == WAIT_MAX));
        core_gnt = i_core_req & ~dbg_gnt;
        if (dbg_gnt && i_dbg_lock) begin
          state_d = ST_DBG_BURST;
        end
      end
      ST_DBG_BURST: begin
        // Exclusive debug ownership; an idle debug master holding the lock
        // keeps the core out.
        dbg_gnt = i_dbg_req;
        if (!i_dbg_lock) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation counter and read-return owner tag
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_dbg_req || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WCNT_W'(1);
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt && !i_core_wren) begin
      owner_d = OWN_CORE;
    end else if (dbg_gnt && !i_dbg_wren) begin
      owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_ARB;
      wait_cnt_q <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command mux: idle fields are forced to zero
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wren  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (core_gnt) begin
      o_mem_req   = 1'b1;
      o_mem_wren  = i_core_wren;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end else if (dbg_gnt) begin
      o_mem_req   = 1'b1;
      o_mem_wren  = i_dbg_wren;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
    end
  end

  assign o_core_gnt   = core_gnt;
  assign o_dbg_gnt    = dbg_gnt;
  assign o_core_stall = i_core_req & ~core_gnt;

  // Read data is steered to whichever master owned last cycle's load.
  assign o_core_rvalid = (owner_q == OWN_CORE);
  assign o_dbg_rvalid  = (owner_q == OWN_DBG);
  assign o_core_rdata  = o_core_rvalid ? i_mem_rdata : '0;
  assign o_dbg_rdata   = o_dbg_rvalid  ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_CORE = 2'd1;
  localparam logic [1:0] O_DBG  = 2'd2;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_core_req, i_core_wren;
  logic [31:0] i_core_addr, i_core_wdata;
  logic        o_core_gnt, o_core_rvalid, o_core_stall;
  logic [31:0] o_core_rdata;
  logic        i_dbg_req, i_dbg_wren, i_dbg_lock;
  logic [31:0] i_dbg_addr, i_dbg_wdata;
  logic        o_dbg_gnt, o_dbg_rvalid;
  logic [31:0] o_dbg_rdata;
  logic        o_mem_req, o_mem_wren;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] data;
  } resp_t;

  resp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_core_req   (i_core_req),
    .i_core_wren  (i_core_wren),
    .i_core_addr  (i_core_addr),
    .i_core_wdata (i_core_wdata),
    .o_core_gnt   (o_core_gnt),
    .o_core_rvalid(o_core_rvalid),
    .o_core_rdata (o_core_rdata),
    .o_core_stall (o_core_stall),
    .i_dbg_req    (i_dbg_req),
    .i_dbg_wren   (i_dbg_wren),
    .i_dbg_lock   (i_dbg_lock),
    .i_dbg_addr   (i_dbg_addr),
    .i_dbg_wdata  (i_dbg_wdata),
    .o_dbg_gnt    (o_dbg_gnt),
    .o_dbg_rvalid (o_dbg_rvalid),
    .o_dbg_rdata  (o_dbg_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_wren   (o_mem_wren),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // Memory contents as a fixed function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a ^ 32'hC0DE_0000) + 32'h1111;
  endfunction

  // Memory model: read data one cycle after a load command, junk otherwise.
  always @(posedge clk) begin
    if (o_mem_req && !o_mem_wren) mem_rdata <= mem_fn(o_mem_addr);
    else                          mem_rdata <= 32'hBAD0_BAD0;
  end

  // Expected memory command {req, wren, addr, wdata} for the given winner.
  function automatic logic [65:0] mem_exp(input logic cg, input logic cw,
                                          input logic [31:0] ca, input logic [31:0] cd,
                                          input logic dg, input logic dw,
                                          input logic [31:0] da, input logic [31:0] dd);
    if (cg) return {1'b1, cw, ca, cd};
    if (dg) return {1'b1, dw, da, dd};
    return 66'd0;
  endfunction

  // Apply one cycle of stimulus (at posedge+1) and queue the expected read return.
  task automatic drive(input logic rst,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [31:0] da, input logic [31:0] dd,
                       input logic exp_cg, input logic exp_dg);
    resp_t e;
    i_reset = rst;
    i_core_req = cr; i_core_wren = cw; i_core_addr = ca; i_core_wdata = cd;
    i_dbg_req = dr; i_dbg_wren = dw; i_dbg_lock = dl; i_dbg_addr = da; i_dbg_wdata = dd;
    if (rst)                   e.owner = O_NONE;
    else if (exp_cg && !cw)    e.owner = O_CORE;
    else if (exp_dg && !dw)    e.owner = O_DBG;
    else                       e.owner = O_NONE;
    e.data = (e.owner == O_CORE) ? mem_fn(ca) : (e.owner == O_DBG) ? mem_fn(da) : 32'h0;
    sb_q.push_back(e);
    #3;
  endtask

  // Advance one clock and check the read return against the scoreboard.
  task automatic tick();
    resp_t e;
    logic [31:0] exp_cd, exp_dd;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty got=0 entries want>=1");
      return;
    end
    e = sb_q.pop_front();
    exp_cd = (e.owner == O_CORE) ? e.data : 32'h0;
    exp_dd = (e.owner == O_DBG)  ? e.data : 32'h0;
    if ({o_core_rvalid, o_dbg_rvalid} !== {e.owner == O_CORE, e.owner == O_DBG}) begin
      failures++;
      $display("FAIL sb_rvalid got core=%b dbg=%b want owner=%0d", o_core_rvalid, o_dbg_rvalid, e.owner);
    end
    checks++;
    if ({o_core_rdata, o_dbg_rdata} !== {exp_cd, exp_dd}) begin
      failures++;
      $display("FAIL sb_rdata got core=%h dbg=%h want core=%h dbg=%h", o_core_rdata, o_dbg_rdata, exp_cd, exp_dd);
    end
    $display("resp owner=%0d core_rv=%b core_rd=%h dbg_rv=%b dbg_rd=%h",
             e.owner, o_core_rvalid, o_core_rdata, o_dbg_rvalid, o_dbg_rdata);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({o_core_gnt, o_dbg_gnt, o_core_stall, o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata} !== 69'd0) begin
      failures++;
      $display("FAIL idle outputs got gnt=%b%b stall=%b mem=%b%b %h %h want all 0",
               o_core_gnt, o_dbg_gnt, o_core_stall, o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata);
    end
    tick();
  endtask

  // Two reset cycles with loads pending on both masters: no read data returns.
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0);
      checks++;
      if ({o_core_gnt, o_dbg_gnt, o_core_stall} !== 3'b100) begin
        failures++;
        $display("FAIL reset[%0d] gnt/stall got=%b want=100", i, {o_core_gnt, o_dbg_gnt, o_core_stall});
      end
      tick();
    end
  endtask

  // Both request every cycle straight out of reset: debug wins on cycle 4 only.
  task automatic test_contention();
    logic cg, dg;
    logic [31:0] ca, cd, da, dd;
    for (int i = 0; i < 6; i++) begin
      dg = (i == 4);
      cg = !dg;
      ca = 32'h200 + 32'(4 * i); cd = 32'h5500 + 32'(i);
      da = 32'h300 + 32'(4 * i); dd = 32'h6600 + 32'(i);
      drive(1'b0, 1'b1, 1'b0, ca, cd, 1'b1, 1'b0, 1'b0, da, dd, cg, dg);
      checks++;
      if ({o_core_gnt, o_dbg_gnt, o_core_stall} !== {cg, dg, !cg}) begin
        failures++;
        $display("FAIL contention[%0d] gnt/stall got=%b want=%b", i,
                 {o_core_gnt, o_dbg_gnt, o_core_stall}, {cg, dg, !cg});
      end
      checks++;
      if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata} !== mem_exp(cg, 1'b0, ca, cd, dg, 1'b0, da, dd)) begin
        failures++;
        $display("FAIL contention[%0d] mem got=%h want=%h", i,
                 {o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata}, mem_exp(cg, 1'b0, ca, cd, dg, 1'b0, da, dd));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_core_load();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({o_core_gnt, o_dbg_gnt, o_core_stall, o_mem_req, o_mem_wren, o_mem_addr} !== {5'b10010, 32'h10}) begin
      failures++;
      $display("FAIL core_load cmd got gnt=%b%b stall=%b req=%b wren=%b addr=%h want 1 0 0 1 0 00000010",
               o_core_gnt, o_dbg_gnt, o_core_stall, o_mem_req, o_mem_wren, o_mem_addr);
    end
    tick();
    idle();
  endtask

  // Core load, debug load, core store (debug denied), debug load on consecutive cycles.
  task automatic test_interleave();
    logic cr[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic cw[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic dr[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic cg[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic dg[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ca, da;
    for (int i = 0; i < 4; i++) begin
      ca = 32'h40 + 32'(16 * i);
      da = 32'h50 + 32'(16 * i);
      drive(1'b0, cr[i], cw[i], ca, 32'h7000 + 32'(i), dr[i], 1'b0, 1'b0, da, 32'h8000 + 32'(i), cg[i], dg[i]);
      checks++;
      if ({o_core_gnt, o_dbg_gnt} !== {cg[i], dg[i]}) begin
        failures++;
        $display("FAIL interleave[%0d] gnt got=%b want=%b", i, {o_core_gnt, o_dbg_gnt}, {cg[i], dg[i]});
      end
      checks++;
      if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata} !==
          mem_exp(cg[i], cw[i], ca, 32'h7000 + 32'(i), dg[i], 1'b0, da, 32'h8000 + 32'(i))) begin
        failures++;
        $display("FAIL interleave[%0d] mem got=%h want=%h", i, {o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata},
                 mem_exp(cg[i], cw[i], ca, 32'h7000 + 32'(i), dg[i], 1'b0, da, 32'h8000 + 32'(i)));
      end
      tick();
    end
    idle();
  endtask

  // Core loads continuously; a locked debug store burst starves first, then
  // owns the port (including an idle locked cycle) until the lock drops.
  task automatic test_burst();
    logic cr, dr, dl, cg, dg;
    logic [31:0] ca, da, dd;
    for (int i = 0; i < 10; i++) begin
      cr = 1'b1; ca = 32'h400 + 32'(4 * i);
      dr = 1'b1; dl = 1'b1; da = 32'h100; dd = 32'hA000_0000;
      cg = 1'b0; dg = 1'b0;
      case (i)
        0, 1, 2, 3: cg = 1'b1;
        4:          dg = 1'b1;
        5:          begin dg = 1'b1; da = 32'h104; dd = 32'hA000_0004; end
        6:          dr = 1'b0;
        7:          begin dg = 1'b1; da = 32'h108; dd = 32'hA000_0008; end
        8:          begin dr = 1'b0; dl = 1'b0; end
        default:    begin dr = 1'b0; dl = 1'b0; cg = 1'b1; end
      endcase
      drive(1'b0, cr, 1'b0, ca, 32'h0, dr, 1'b1, dl, da, dd, cg, dg);
      checks++;
      if ({o_core_gnt, o_dbg_gnt, o_core_stall} !== {cg, dg, !cg}) begin
        failures++;
        $display("FAIL burst[%0d] gnt/stall got=%b want=%b", i,
                 {o_core_gnt, o_dbg_gnt, o_core_stall}, {cg, dg, !cg});
      end
      checks++;
      if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata} !== mem_exp(cg, 1'b0, ca, 32'h0, dg, 1'b1, da, dd)) begin
        failures++;
        $display("FAIL burst[%0d] mem got=%h want=%h", i,
                 {o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata}, mem_exp(cg, 1'b0, ca, 32'h0, dg, 1'b1, da, dd));
      end
      tick();
    end
    idle();
  endtask

  // Reset while in a burst returns to arbitration; a held lock alone does not
  // re-enter the burst.
  task automatic test_midburst_reset();
    logic rst, cr, dr, cg, dg;
    logic [31:0] ca;
    for (int i = 0; i < 5; i++) begin
      rst = (i == 2);
      cr  = (i != 0);
      dr  = (i == 0);
      ca  = 32'h80 + 32'(4 * i);
      cg  = (i >= 3);
      dg  = (i == 0);
      drive(rst, cr, 1'b0, ca, 32'h0, dr, 1'b1, 1'b1, 32'h180, 32'hB000_0000, cg, dg);
      checks++;
      if ({o_core_gnt, o_dbg_gnt, o_core_stall} !== {cg, dg, cr & !cg}) begin
        failures++;
        $display("FAIL midreset[%0d] gnt/stall got=%b want=%b", i,
                 {o_core_gnt, o_dbg_gnt, o_core_stall}, {cg, dg, cr & !cg});
      end
      tick();
    end
    idle();
  endtask

  initial begin
    i_reset = 1'b1;
    i_core_req = 1'b0; i_core_wren = 1'b0; i_core_addr = '0; i_core_wdata = '0;
    i_dbg_req = 1'b0; i_dbg_wren = 1'b0; i_dbg_lock = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_core_load();
    test_interleave();
    test_burst();
    test_midburst_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
